// File: rtl/key_debounce_multi_pkg.sv
// Shared types and helpers for the multi-key debouncer.
// Contents: key_st_t channel state enum, MS_PER_S, tick_div() for the 1 ms prescaler.
package key_pkg;

   typedef enum logic [1:0] {
      REL = 2'd0,
      PRS = 2'd1,
      LNG = 2'd2
   } key_st_t;

   localparam int unsigned MS_PER_S = 1000;

   // Clock cycles per 1 ms tick.
   function automatic int unsigned tick_div(input int unsigned clk_hz);
      return clk_hz / MS_PER_S;
   endfunction

endpackage

// File: rtl/key_debounce_multi_ms_tick_gen.sv
// Shared 1 ms prescaler: tick is high for one cycle every DIV cycles.
// Ports: clk, rst (sync, active-high), tick (registered pulse).
module ms_tick_gen #(
   parameter int unsigned DIV = 50_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running divider, tick registered on wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer and event generator for active-low buttons.
// Ports: clk, rst (sync, active-high), key_in (raw, 1 = released),
//        key_state (debounced level, 1 = pressed), key_press / key_release /
//        key_long / key_repeat (one-cycle event pulses per key).
// Optional: define KEY_AUTOREPEAT_EN to enable key_repeat; otherwise it is 0.
module key_debounce_multi #(
   parameter int unsigned NUM_KEYS    = 4,
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned LONG_MS     = 1000,
   parameter int unsigned REPEAT_MS   = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat
);

   import key_pkg::*;

   localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
   localparam int unsigned DEB_W    = $clog2(DEBOUNCE_MS + 1);
   localparam int unsigned HOLD_W   = $clog2(LONG_MS + 1);

   logic tick;

   ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      logic [1:0]        sync_q;
      logic              sync_p;
      logic [DEB_W-1:0]  deb_cnt;
      logic [HOLD_W-1:0] hold_cnt;
      key_st_t           state, state_nx;
      logic              differ_c, acc_c, long_hit_c;
      logic              press_c, release_c, long_c, repeat_c;
      logic              state_q, press_q, release_q, long_q, repeat_q;

      // Two-flop synchronizer, idles released.
      always_ff @(posedge clk) begin
         if (rst) sync_q <= 2'b11;
         else     sync_q <= {sync_q[0], key_in[i]};
      end

      assign sync_p     = ~sync_q[1];
      assign differ_c   = sync_p != (state != REL);
      assign acc_c      = tick && differ_c && (deb_cnt == DEB_W'(DEBOUNCE_MS - 1));
      assign long_hit_c = tick && (state == PRS) && (hold_cnt == HOLD_W'(LONG_MS - 1));

      // Debounce counter: counts ticks the synced level disagrees with the accepted one.
      always_ff @(posedge clk) begin
         if (rst) begin
            deb_cnt <= '0;
         end else if (tick) begin
            if (!differ_c || acc_c) deb_cnt <= '0;
            else                    deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end

      // Hold counter: held at 0 while released, saturates at LONG_MS.
      always_ff @(posedge clk) begin
         if (rst || (state == REL)) begin
            hold_cnt <= '0;
         end else if (tick && (hold_cnt != HOLD_W'(LONG_MS))) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end

      // State register.
      always_ff @(posedge clk) begin
         if (rst) state <= REL;
         else     state <= state_nx;
      end

      // Next state: release acceptance takes priority over the long threshold.
      always_comb begin
         state_nx = state;
         unique case (state)
            REL:     if (acc_c) state_nx = PRS;
            PRS:     if (acc_c) state_nx = REL;
                     else if (long_hit_c) state_nx = LNG;
            LNG:     if (acc_c) state_nx = REL;
            default: state_nx = REL;
         endcase
      end

      // Event decode.
      always_comb begin
         press_c   = 1'b0;
         release_c = 1'b0;
         long_c    = 1'b0;
         unique case (state)
            REL: press_c = acc_c;
            PRS: begin
               release_c = acc_c;
               long_c    = long_hit_c && !acc_c;
            end
            LNG: release_c = acc_c;
            default: ;
         endcase
      end

`ifdef KEY_AUTOREPEAT_EN
      localparam int unsigned REP_W = $clog2(REPEAT_MS + 1);
      logic [REP_W-1:0] rep_cnt;
      logic             rep_wrap_c;

      assign rep_wrap_c = rep_cnt == REP_W'(REPEAT_MS - 1);
      assign repeat_c   = tick && (state == LNG) && !acc_c && rep_wrap_c;

      // Repeat interval counter, restarts on every entry to LNG.
      always_ff @(posedge clk) begin
         if (rst || (state != LNG)) begin
            rep_cnt <= '0;
         end else if (tick) begin
            if (rep_wrap_c) rep_cnt <= '0;
            else            rep_cnt <= rep_cnt + REP_W'(1);
         end
      end
`else
      assign repeat_c = 1'b0;
`endif

      // Registered outputs.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state_q   <= state_nx != REL;
            press_q   <= press_c;
            release_q <= release_c;
            long_q    <= long_c;
            repeat_q  <= repeat_c;
         end
      end

      assign key_state[i]   = state_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;
      assign key_repeat[i]  = repeat_q;
   end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Parametrised multi-channel debouncer and key-event generator for the ChronoX front panel. It replaces the fixed four-key debounce logic inside the clock top level. It takes raw active-low buttons and produces clean level and pulse events per key: press, release and long-press, with optional auto-repeat. Mode, set and adjust logic in the clock consume these one-cycle event pulses.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- CLK_HZ, 50_000_000: system clock frequency; the 1 ms tick period is CLK_HZ/1000 cycles.
- DEBOUNCE_MS, 10: consecutive ms ticks a new level must persist before it is accepted.
- LONG_MS, 1000: ms held after press acceptance before the long-press event fires.
- REPEAT_MS, 200: auto-repeat interval. Used only with KEY_AUTOREPEAT_EN.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: synchronous reset, active-high.
- key_in, input, NUM_KEYS: raw buttons, active-low (1 = released), asynchronous to clk.
- key_state, output, NUM_KEYS: debounced level, 1 = pressed.
- key_press, output, NUM_KEYS: one-cycle pulse when a press is accepted.
- key_release, output, NUM_KEYS: one-cycle pulse when a release is accepted.
- key_long, output, NUM_KEYS: one-cycle pulse when the hold reaches LONG_MS.
- key_repeat, output, NUM_KEYS: one-cycle repeat pulse. Tied to 0 without KEY_AUTOREPEAT_EN.

Behaviour:
- Reset:
  - Decided: one clock; reset is synchronous and active-high.
  - While rst=1: all outputs 0, all channels in REL, all counters 0.
  - Synchronizer flops load 1 (idle). The tick prescaler clears.
- Synchronizer: per key, two flops on key_in, then inverted to give sync_p (1 = pressed).
- Tick: one shared prescaler asserts tick for 1 cycle every CLK_HZ/1000 cycles. Its counter width is $clog2(CLK_HZ/1000).
- Debounce counter (per channel): on each tick, if sync_p differs from the accepted level, deb_cnt increments; otherwise deb_cnt clears to 0.
- Acceptance: a level change is accepted on the tick where deb_cnt == DEBOUNCE_MS-1 and sync_p still differs. deb_cnt then clears.
- Glitch rejection: any bounce back to the accepted level before acceptance clears deb_cnt, so no event is generated.
- Per-channel FSM:
  - REL: on press acceptance go to PRS; key_state=1; key_press=1 for that cycle; hold_cnt=0.
  - PRS: hold_cnt increments per tick.
    - Release accepted: go to REL, key_release=1, key_state=0.
    - hold_cnt reaches LONG_MS-1 on a tick: go to LNG, key_long=1, rep_cnt=0.
  - LNG: release accepted goes to REL with key_release=1. No further key_long pulses.
- Simultaneous events: if release acceptance and the long threshold fall on the same tick, release wins. key_release fires; key_long does not fire.
- Latency: press pulse appears 2 sync cycles plus DEBOUNCE_MS ticks (minus 0 to 1 tick of phase) after a clean edge. Accepted edges are therefore between (DEBOUNCE_MS-1) ms and DEBOUNCE_MS ms after the edge.
- Independence: channels are fully independent. Any combination of keys may fire events in the same cycle.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_MS+1) bits.
  - hold_cnt is $clog2(LONG_MS+1) bits and saturates; it never wraps.
  - rep_cnt is $clog2(REPEAT_MS+1) bits.
- Reset mid-press: the channel returns to REL. A key still held after reset must re-debounce for the full window and then produces key_press.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined: in LNG, rep_cnt increments per tick. On reaching REPEAT_MS-1, key_repeat pulses for 1 cycle and rep_cnt clears. Repeats continue until release is accepted. The first repeat comes REPEAT_MS after key_long.
- Undefined: no rep_cnt logic is generated, and key_repeat is constant 0.

Decomposition:
- Package key_pkg holds:
  - the state enum key_st_t (REL, PRS, LNG);
  - MS_PER_S;
  - the localparam helper for the tick divider (CLK_HZ/1000).
- Sub-module ms_tick_gen: the prescaler producing a 1-cycle tick. It is instantiated once and shared by all channels.
- Per-channel logic is a generate loop. No per-channel sub-module is needed.

Test Plan (CLK_HZ=10_000, so tick = 10 cycles; DEBOUNCE_MS=10, LONG_MS=50, REPEAT_MS=20):
- Glitch rejection: key_in=4'b1101 for 5 ms, then 4'b1111 -> no key_press, key_state stays 0.
- Valid press: key_in=4'b1101 held 20 ms -> a single key_press[1] pulse 10 ms (±1 tick) after the edge; key_state[1]=1 until release debounces. Releasing then gives key_release[1] 10 ms after the rising edge.
- Long press: hold key 0 for 100 ms.
  - key_long[0] fires exactly once, 50 ms after key_press.
  - With KEY_AUTOREPEAT_EN: key_repeat[0] at +20 ms and +40 ms after key_long.
  - Without it: key_repeat stays 0.
- Bounce: toggle key_in[2] every 3 ms for 30 ms, then hold low 15 ms -> exactly one key_press[2], only after the hold.
- Reset mid-press: assert rst for 1 cycle while key 3 is in PRS.
  - All outputs go to 0 on the next edge.
  - With the key still held, key_press[3] fires again after 10 ms.
- Multi-key: press keys 0 and 3 on the same cycle -> key_press[0] and key_press[3] in the same cycle; the other channels stay silent.
